// File: rtl/gshare_predictor.sv
// gshare branch direction predictor: 2^IDX_W saturating counters indexed by PC ^ GHR,
// trained non-speculatively by the branch unit with the index returned at prediction time.
module gshare_predictor #(
  parameter int CNT_W    = 2,
  parameter int IDX_W    = 6,
  parameter int HIST_W   = 6,
  parameter int INIT_CNT = (1 << CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             request,
  input  logic [IDX_W-1:0] req_pc,
  input  logic             result,
  input  logic             taken,
  input  logic [IDX_W-1:0] upd_idx,
  output logic             prediction,
  output logic             pred_valid,
  output logic [IDX_W-1:0] pred_idx,
  output logic             pred_strong
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt, input logic up);
    logic [CNT_W-1:0] nxt;
    if (up) begin
      nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1'b1);
    end else begin
      nxt = (cnt == CNT_ZERO) ? cnt : cnt - CNT_W'(1'b1);
    end
    return nxt;
  endfunction

  function automatic logic is_saturated(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_ZERO) || (cnt == CNT_MAX);
  endfunction

  logic [CNT_W-1:0]  tbl_q [DEPTH];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0]  idx_s;
  logic [CNT_W-1:0]  rd_cnt_s;
  logic [CNT_W-1:0]  upd_cnt_d;
  logic              prediction_q;
  logic              pred_valid_q;
  logic [IDX_W-1:0]  pred_idx_q;
  logic              pred_strong_q;

  // Lookup index, trained counter value and shifted history
  always_comb begin
    idx_s     = req_pc ^ IDX_W'(ghr_q);
    rd_cnt_s  = tbl_q[idx_s];
    upd_cnt_d = sat_step(tbl_q[upd_idx], taken);
    ghr_d     = result ? ((ghr_q << 1) | HIST_W'(taken)) : ghr_q;
  end

  // Reads see pre-edge table and GHR, so a same-cycle update is visible only next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= CNT_INIT;
      end
      ghr_q         <= {HIST_W{1'b0}};
      prediction_q  <= 1'b0;
      pred_valid_q  <= 1'b0;
      pred_idx_q    <= {IDX_W{1'b0}};
      pred_strong_q <= 1'b0;
    end else begin
      if (result) begin
        tbl_q[upd_idx] <= upd_cnt_d;
      end
      ghr_q        <= ghr_d;
      pred_valid_q <= request;
      if (request) begin
        prediction_q  <= rd_cnt_s[CNT_W-1];
        pred_idx_q    <= idx_s;
        pred_strong_q <= is_saturated(rd_cnt_s);
      end
    end
  end

  assign prediction  = prediction_q;
  assign pred_valid  = pred_valid_q;
  assign pred_idx    = pred_idx_q;
  assign pred_strong = pred_strong_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed vector table, async-reset and wide-counter sequences,
// and randomized traffic against an arithmetic reference model.
module tb_gshare_predictor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_request = 1'b0, a_result = 1'b0, a_taken = 1'b0;
  logic [3:0] a_req_pc = 4'h0, a_upd_idx = 4'h0;
  logic       a_prediction, a_pred_valid, a_pred_strong;
  logic [3:0] a_pred_idx;

  logic       b_request = 1'b0, b_result = 1'b0, b_taken = 1'b0;
  logic [3:0] b_req_pc = 4'h0, b_upd_idx = 4'h0;
  logic       b_prediction, b_pred_valid, b_pred_strong;
  logic [3:0] b_pred_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gshare_predictor #(.CNT_W(2), .IDX_W(4), .HIST_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .request(a_request), .req_pc(a_req_pc),
    .result(a_result), .taken(a_taken), .upd_idx(a_upd_idx),
    .prediction(a_prediction), .pred_valid(a_pred_valid),
    .pred_idx(a_pred_idx), .pred_strong(a_pred_strong)
  );

  gshare_predictor #(.CNT_W(3), .IDX_W(4), .HIST_W(4), .INIT_CNT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .request(b_request), .req_pc(b_req_pc),
    .result(b_result), .taken(b_taken), .upd_idx(b_upd_idx),
    .prediction(b_prediction), .pred_valid(b_pred_valid),
    .pred_idx(b_pred_idx), .pred_strong(b_pred_strong)
  );

  typedef struct {
    bit       rst;
    bit       req;
    bit [3:0] pc;
    bit       res;
    bit       tk;
    bit [3:0] u;
    bit       ev;
    bit       ep;
    bit [3:0] ei;
    bit       es;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(bit rst, bit req, bit [3:0] pc, bit res, bit tk, bit [3:0] u,
                              bit ev, bit ep, bit [3:0] ei, bit es);
    vec_t v;
    v.rst = rst; v.req = req; v.pc = pc; v.res = res; v.tk = tk; v.u = u;
    v.ev = ev; v.ep = ep; v.ei = ei; v.es = es;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    a_request = 1'b0; a_result = 1'b0; b_request = 1'b0; b_result = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step_a(input bit req, input bit [3:0] pc, input bit res, input bit tk,
                        input bit [3:0] u);
    a_request = req; a_req_pc = pc; a_result = res; a_taken = tk; a_upd_idx = u;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input bit req, input bit [3:0] pc, input bit res, input bit tk,
                        input bit [3:0] u);
    b_request = req; b_req_pc = pc; b_result = res; b_taken = tk; b_upd_idx = u;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    if (v.rst) do_reset();
    step_a(v.req, v.pc, v.res, v.tk, v.u);
    check($sformatf("vec%0d_valid", i), a_pred_valid, v.ev);
    check($sformatf("vec%0d_pred", i), a_prediction, v.ep);
    check($sformatf("vec%0d_idx", i), a_pred_idx, v.ei);
    check($sformatf("vec%0d_strong", i), a_pred_strong, v.es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_m [16];
    int ghr_m;
    int cnt;
    int ghr_b;
    bit ev, ep, es;
    bit [3:0] ei;
    bit req, res, tk;
    bit [3:0] pc, u;

    vecs[0]  = mk(1, 1, 4'h0, 0, 0, 4'h0, 1, 1, 4'h0, 1);
    vecs[1]  = mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h0, 1);
    vecs[2]  = mk(0, 0, 4'h0, 1, 0, 4'h3, 0, 1, 4'h0, 1);
    vecs[3]  = mk(0, 0, 4'h0, 1, 0, 4'h3, 0, 1, 4'h0, 1);
    vecs[4]  = mk(0, 0, 4'h0, 1, 0, 4'h3, 0, 1, 4'h0, 1);
    vecs[5]  = mk(0, 0, 4'h0, 1, 0, 4'h3, 0, 1, 4'h0, 1);
    vecs[6]  = mk(0, 1, 4'h3, 0, 0, 4'h0, 1, 0, 4'h3, 1);
    vecs[7]  = mk(0, 0, 4'h0, 1, 0, 4'h3, 0, 0, 4'h3, 1);
    vecs[8]  = mk(0, 1, 4'h3, 0, 0, 4'h0, 1, 0, 4'h3, 1);
    vecs[9]  = mk(0, 0, 4'h0, 1, 1, 4'h0, 0, 1, 4'h3, 1);
    vecs[10] = mk(0, 0, 4'h0, 1, 1, 4'h0, 0, 1, 4'h3, 1);
    vecs[11] = mk(0, 0, 4'h0, 1, 1, 4'h0, 0, 1, 4'h3, 1);
    vecs[12] = mk(0, 1, 4'h5, 0, 0, 4'h0, 1, 1, 4'h2, 1);
    vecs[13] = mk(1, 0, 4'h0, 1, 0, 4'h0, 0, 0, 4'h0, 0);
    vecs[14] = mk(0, 1, 4'h0, 1, 0, 4'h0, 1, 1, 4'h0, 0);
    vecs[15] = mk(0, 1, 4'h0, 0, 0, 4'h0, 1, 0, 4'h0, 0);

    #3;
    check("reset_valid", a_pred_valid, 1'b0);
    check("reset_pred", a_prediction, 1'b0);
    check("reset_idx", a_pred_idx, 4'h0);
    check("reset_strong", a_pred_strong, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i <= 8; i++) apply_vec(i);

    // Asynchronous reset between edges, then a fresh strongly-taken table
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", a_pred_valid, 1'b0);
    check("async_pred", a_prediction, 1'b0);
    check("async_idx", a_pred_idx, 4'h0);
    check("async_strong", a_pred_strong, 1'b0);
    #1;
    rst_n = 1'b1;
    step_a(1, 4'h3, 0, 0, 4'h0);
    check("post_reset_pred", a_prediction, 1'b1);
    check("post_reset_valid", a_pred_valid, 1'b1);

    for (int i = 9; i <= 15; i++) apply_vec(i);

    // Randomized traffic against an arithmetic model
    do_reset();
    for (int i = 0; i < 16; i++) cnt_m[i] = 3;
    ghr_m = 0;
    ev = 1'b0; ep = 1'b0; ei = 4'h0; es = 1'b0;
    for (int n = 0; n < 400; n++) begin
      req = 1'($urandom_range(0, 1));
      pc  = 4'($urandom_range(0, 15));
      res = 1'($urandom_range(0, 1));
      tk  = 1'($urandom_range(0, 1));
      u   = ($urandom_range(0, 3) == 0) ? 4'(pc ^ ghr_m) : 4'($urandom_range(0, 15));
      ev = req;
      if (req) begin
        ei  = 4'(pc ^ ghr_m);
        cnt = cnt_m[ei];
        ep  = (cnt >= 2);
        es  = (cnt == 0) || (cnt == 3);
      end
      if (res) begin
        if (tk) cnt_m[u] = (cnt_m[u] < 3) ? cnt_m[u] + 1 : 3;
        else    cnt_m[u] = (cnt_m[u] > 0) ? cnt_m[u] - 1 : 0;
        ghr_m = (ghr_m * 2 + int'(tk)) % 16;
      end
      step_a(req, pc, res, tk, u);
      check($sformatf("rand%0d {valid,pred,idx,strong}", n),
            {a_pred_valid, a_prediction, a_pred_idx, a_pred_strong}, {ev, ep, ei, es});
    end
    a_request = 1'b0; a_result = 1'b0;

    // Wide counter starting at 0: climb, saturate at 7, then fall back across the midpoint
    do_reset();
    ghr_b = 0;
    u = 4'h9;
    step_b(1, u, 0, 0, 4'h0);
    check("b_init_pred", b_prediction, 1'b0);
    check("b_init_strong", b_pred_strong, 1'b1);
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      step_b(0, 4'h0, 1, 1, u);
      ghr_b = ((ghr_b << 1) | 1) & 15;
      cnt = (cnt < 7) ? cnt + 1 : 7;
      step_b(1, 4'(u ^ ghr_b), 0, 0, 4'h0);
      check($sformatf("b_up%0d_pred", k), b_prediction, (cnt >= 4));
      check($sformatf("b_up%0d_strong", k), b_pred_strong, (cnt == 7));
      check($sformatf("b_up%0d_idx", k), b_pred_idx, u);
    end
    for (int j = 1; j <= 4; j++) begin
      step_b(0, 4'h0, 1, 0, u);
      ghr_b = (ghr_b << 1) & 15;
      cnt = cnt - 1;
      step_b(1, 4'(u ^ ghr_b), 0, 0, 4'h0);
      check($sformatf("b_down%0d_pred", j), b_prediction, (cnt >= 4));
      check($sformatf("b_down%0d_idx", j), b_pred_idx, u);
    end
    b_request = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
